// File: rtl/tone_pkg.sv
// Shared types and constants for the stereo test-tone NCO.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package tone_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_e;

    localparam logic [7:0] AMP_UNITY = 8'd128;
    localparam int         AMP_SHIFT = 7;

    // Amplitudes above unity clamp to unity so the scaled result never overflows.
    function automatic logic [7:0] amp_sat(input logic [7:0] amp);
        return (amp > AMP_UNITY) ? AMP_UNITY : amp;
    endfunction

endpackage

// File: rtl/tone_sine_lut.sv
// Quarter-wave sine ROM with quadrant mirror/negate; one read per cycle.
// Latency: 1 cycle (registered output), phase_i -> sine_o.
// Backpressure: none; a new phase is consumed every cycle.
module tone_sine_lut #(
    parameter int SAMPLE_W = 16,
    parameter int LUT_AW   = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [LUT_AW+1:0]   phase_i,
    output logic [SAMPLE_W-1:0] sine_o
);
    localparam int  DEPTH = 2 ** LUT_AW;
    localparam real PI    = 3.14159265358979323846;
    localparam real PEAK  = real'(2 ** (SAMPLE_W - 1) - 1);

    // Positive quarter wave sampled at bin centres, so entries 0 and DEPTH-1
    // mirror cleanly without duplicating the zero crossing or the peak.
    logic [SAMPLE_W-2:0] w_rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam real ANG = PI / 2.0 * (real'(k) + 0.5) / real'(DEPTH);
        localparam int  VAL = $rtoi($floor(PEAK * $sin(ANG) + 0.5));
        assign w_rom[k] = VAL[SAMPLE_W-2:0];
    end

    logic [1:0]          w_quad;
    logic [LUT_AW-1:0]   w_idx;
    logic [SAMPLE_W-1:0] w_mag;
    logic [SAMPLE_W-1:0] r_sine;

    assign w_quad = phase_i[LUT_AW+1:LUT_AW];
    assign w_idx  = w_quad[0] ? ~phase_i[LUT_AW-1:0] : phase_i[LUT_AW-1:0];
    assign w_mag  = {1'b0, w_rom[w_idx]};

    // Registered table read; the second half-cycle of the wave is negated.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sine <= '0;
        end else begin
            r_sine <= w_quad[1] ? -w_mag : w_mag;
        end
    end

    assign sine_o = r_sine;

endmodule

// File: rtl/tone_nco.sv
// Stereo test-tone NCO: saw/square/triangle/sine with amplitude scaling; TONE_NCO_SINE_EN builds the sine LUT.
// Latency: sample_valid_o rises 3 cycles after the accepting sample_req_i edge; fully pipelined.
// Backpressure: none; every request is accepted and emitted, sample_o holds between strobes.
module tone_nco
    import tone_pkg::*;
#(
    parameter int ACC_W    = 24,
    parameter int SAMPLE_W = 16,
    parameter int LUT_AW   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ACC_W-1:0]      fcw_l_i,
    input  logic [ACC_W-1:0]      fcw_r_i,
    input  logic [1:0]            wave_i,
    input  logic [7:0]            amp_i,
    input  logic                  phase_rst_i,
    input  logic                  sample_req_i,
    output logic [2*SAMPLE_W-1:0] sample_o,
    output logic                  sample_valid_o
);
    localparam logic [SAMPLE_W-1:0] MSB_MASK = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] FULL_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] FULL_NEG = MSB_MASK | SAMPLE_W'(1);

    if (ACC_W < SAMPLE_W || LUT_AW < 1 || LUT_AW + 2 > SAMPLE_W) begin : g_cfg_check
        $error("tone_nco: need ACC_W >= SAMPLE_W and 1 <= LUT_AW <= SAMPLE_W-2");
    end

    // Saw, square and triangle from the phase word; sine select falls back to triangle here.
    function automatic logic [SAMPLE_W-1:0] shape(input logic [SAMPLE_W-1:0] p, input wave_e w);
        logic [SAMPLE_W-2:0] f;
        f = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
        case (w)
            WAVE_SAW:    return p ^ MSB_MASK;
            WAVE_SQUARE: return p[SAMPLE_W-1] ? FULL_NEG : FULL_POS;
            default:     return {f, 1'b0} ^ MSB_MASK;
        endcase
    endfunction

    // Signed multiply by a 0..128 amplitude, floor-divide by 128; always fits SAMPLE_W.
    function automatic logic [SAMPLE_W-1:0] scale(input logic [SAMPLE_W-1:0] w, input logic [7:0] a);
        logic signed [SAMPLE_W+8:0] prod;
        prod = $signed(w) * $signed({1'b0, a});
        prod = prod >>> AMP_SHIFT;
        return prod[SAMPLE_W-1:0];
    endfunction

    logic [ACC_W-1:0]      r_acc_l, r_acc_r;
    logic [ACC_W-1:0]      w_acc_l_nxt, w_acc_r_nxt;
    logic                  r_s1_vld;
    logic [SAMPLE_W-1:0]   r_s1_phase_l, r_s1_phase_r;
    wave_e                 r_s1_wave;
    logic [7:0]            r_s1_amp;
    logic                  r_s2_vld;
    logic [SAMPLE_W-1:0]   r_s2_wave_l, r_s2_wave_r;
    logic [7:0]            r_s2_amp;
    logic [SAMPLE_W-1:0]   w_s2_l, w_s2_r;
    logic                  r_out_vld;
    logic [2*SAMPLE_W-1:0] r_out;

    assign w_acc_l_nxt = r_acc_l + fcw_l_i;
    assign w_acc_r_nxt = r_acc_r + fcw_r_i;

    // S0/S1: advance accumulators on request (realign wins) and capture phase, mode and amplitude.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_acc_l      <= '0;
            r_acc_r      <= '0;
            r_s1_vld     <= 1'b0;
            r_s1_phase_l <= '0;
            r_s1_phase_r <= '0;
            r_s1_wave    <= WAVE_SAW;
            r_s1_amp     <= '0;
        end else begin
            if (phase_rst_i) begin
                r_acc_l <= '0;
                r_acc_r <= '0;
            end else if (sample_req_i) begin
                r_acc_l <= w_acc_l_nxt;
                r_acc_r <= w_acc_r_nxt;
            end
            r_s1_vld <= sample_req_i;
            if (sample_req_i) begin
                r_s1_phase_l <= phase_rst_i ? '0 : w_acc_l_nxt[ACC_W-1 -: SAMPLE_W];
                r_s1_phase_r <= phase_rst_i ? '0 : w_acc_r_nxt[ACC_W-1 -: SAMPLE_W];
                r_s1_wave    <= wave_e'(wave_i);
                r_s1_amp     <= amp_sat(amp_i);
            end
        end
    end

    // S2: register the shaped waveform; the sine LUT registers its own read alongside.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s2_vld    <= 1'b0;
            r_s2_wave_l <= '0;
            r_s2_wave_r <= '0;
            r_s2_amp    <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_wave_l <= shape(r_s1_phase_l, r_s1_wave);
                r_s2_wave_r <= shape(r_s1_phase_r, r_s1_wave);
                r_s2_amp    <= r_s1_amp;
            end
        end
    end

`ifdef TONE_NCO_SINE_EN
    logic [SAMPLE_W-1:0] w_sine_l, w_sine_r;
    logic                r_s2_is_sine;

    tone_sine_lut #(.SAMPLE_W(SAMPLE_W), .LUT_AW(LUT_AW)) u_sine_l (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .phase_i (r_s1_phase_l[SAMPLE_W-1 -: LUT_AW+2]),
        .sine_o  (w_sine_l)
    );

    tone_sine_lut #(.SAMPLE_W(SAMPLE_W), .LUT_AW(LUT_AW)) u_sine_r (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .phase_i (r_s1_phase_r[SAMPLE_W-1 -: LUT_AW+2]),
        .sine_o  (w_sine_r)
    );

    // S2: remember whether this sample takes the LUT path.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s2_is_sine <= 1'b0;
        end else if (r_s1_vld) begin
            r_s2_is_sine <= (r_s1_wave == WAVE_SINE);
        end
    end

    assign w_s2_l = r_s2_is_sine ? w_sine_l : r_s2_wave_l;
    assign w_s2_r = r_s2_is_sine ? w_sine_r : r_s2_wave_r;
`else
    assign w_s2_l = r_s2_wave_l;
    assign w_s2_r = r_s2_wave_r;
`endif

    // S3: amplitude scale into the output register, held until the next valid sample.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_out_vld <= 1'b0;
            r_out     <= '0;
        end else begin
            r_out_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_out <= {scale(w_s2_l, r_s2_amp), scale(w_s2_r, r_s2_amp)};
            end
        end
    end

    assign sample_o       = r_out;
    assign sample_valid_o = r_out_vld;

endmodule

// File: tb/tb_tone_nco.sv
// Scoreboard bench for tone_nco: expectations queued at request time, popped on each strobe.
// Latency: each expectation carries its due cycle (request cycle + 3).
// Backpressure: none; unexpected or missing strobes are reported.
module tb_tone_nco;
    import tone_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] fcw_l, fcw_r;
    logic [1:0]  wave;
    logic [7:0]  amp;
    logic        prst, req;
    logic [31:0] sample;
    logic        vld;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          strobes = 0;
    logic [23:0] m_acc_l, m_acc_r;

    always #5 clk = ~clk;

    tone_nco #(.ACC_W(24), .SAMPLE_W(16), .LUT_AW(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .fcw_l_i        (fcw_l),
        .fcw_r_i        (fcw_r),
        .wave_i         (wave),
        .amp_i          (amp),
        .phase_rst_i    (prst),
        .sample_req_i   (req),
        .sample_o       (sample),
        .sample_valid_o (vld)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        if (vld === 1'b1) begin
            strobes++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe with sample %h at cycle %0d, required no strobe", sample, cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (sample !== mon_e.dat) begin
                    errors++;
                    $display("FAIL sample_value: got %h, required %h", sample, mon_e.dat);
                end
                checks++;
                if (cyc !== mon_e.due) begin
                    errors++;
                    $display("FAIL strobe_latency: got cycle %0d, required cycle %0d", cyc, mon_e.due);
                end
            end
        end
    end

    function automatic logic [15:0] m_wave(input logic [15:0] p, input logic [1:0] w);
        logic [14:0] f;
        int          k;
        int          v;
        case (w)
            2'd0: return p ^ 16'h8000;
            2'd1: return p[15] ? 16'h8001 : 16'h7FFF;
`ifdef TONE_NCO_SINE_EN
            2'd3: begin
                k = int'(p[13:6]);
                if (p[14]) k = 255 - k;
                v = $rtoi($floor(32767.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 512.0) + 0.5));
                if (p[15]) v = -v;
                return v[15:0];
            end
`endif
            default: begin
                f = p[15] ? ~p[14:0] : p[14:0];
                return {f, 1'b0} ^ 16'h8000;
            end
        endcase
    endfunction

    function automatic logic [15:0] m_scale(input logic [15:0] w, input logic [7:0] a);
        int aa;
        int prod;
        aa   = (a > 8'd128) ? 128 : int'(a);
        prod = int'($signed(w)) * aa;
        prod = prod >>> 7;
        return prod[15:0];
    endfunction

    // One cycle of stimulus; a request queues either a fixed value or the model value.
    task automatic step(input logic r, input logic pr, input logic [1:0] w, input logic [7:0] a,
                        input logic [23:0] fl, input logic [23:0] fr,
                        input logic use_c, input logic [31:0] cval);
        exp_t e;
        @(posedge clk);
        #1;
        req = r; prst = pr; wave = w; amp = a; fcw_l = fl; fcw_r = fr;
        if (pr) begin
            m_acc_l = '0;
            m_acc_r = '0;
        end else if (r) begin
            m_acc_l = m_acc_l + fl;
            m_acc_r = m_acc_r + fr;
        end
        if (r) begin
            e.dat = use_c ? cval : {m_scale(m_wave(m_acc_l[23:8], w), a),
                                    m_scale(m_wave(m_acc_r[23:8], w), a)};
            e.due = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, wave, amp, fcw_l, fcw_r, 1'b0, 32'h0);
    endtask

    // Wait (bounded) for all queued expectations to be consumed.
    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_strobe: got %0d samples outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; prst = 1'b0; wave = 2'd0; amp = 8'd128;
        fcw_l = '0; fcw_r = '0;
        m_acc_l = '0; m_acc_r = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sample !== 32'h0) begin
            errors++;
            $display("FAIL reset_sample: got %h, required 00000000", sample);
        end
        checks++;
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, required 0", vld);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_saw();
        step(1'b1, 1'b0, WAVE_SAW, 8'd128, 24'h010000, 24'h010000, 1'b1, 32'h8100_8100);
        step(1'b1, 1'b0, WAVE_SAW, 8'd128, 24'h010000, 24'h010000, 1'b1, 32'h8200_8200);
        idle();
        drain();
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, WAVE_SQUARE, 8'd128, 24'h800000, 24'h000000, 1'b0, 32'h0);
        step(1'b1, 1'b0, WAVE_SQUARE, 8'd128, 24'h800000, 24'h000000, 1'b1, 32'h8001_7FFF);
        step(1'b1, 1'b0, WAVE_SQUARE, 8'd128, 24'h800000, 24'h000000, 1'b1, 32'h7FFF_7FFF);
        idle();
        drain();
    endtask

    task automatic test_amplitude();
        step(1'b1, 1'b1, WAVE_SQUARE, 8'd64,  24'h800000, 24'h800000, 1'b1, 32'h3FFF_3FFF);
        step(1'b1, 1'b0, WAVE_SQUARE, 8'd64,  24'h800000, 24'h800000, 1'b1, 32'hC000_C000);
        step(1'b1, 1'b1, WAVE_SQUARE, 8'd200, 24'h800000, 24'h800000, 1'b1, 32'h7FFF_7FFF);
        idle();
        drain();
    endtask

    task automatic test_sine();
`ifdef TONE_NCO_SINE_EN
        step(1'b1, 1'b1, WAVE_SINE, 8'd128, 24'h0, 24'h0, 1'b1, 32'h0065_0065);
`else
        step(1'b1, 1'b1, WAVE_SINE, 8'd128, 24'h0, 24'h0, 1'b1, 32'h8000_8000);
`endif
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        int snap;
        step(1'b0, 1'b1, WAVE_SAW, 8'd128, 24'h0, 24'h0, 1'b0, 32'h0);
        snap = strobes;
        step(1'b1, 1'b0, WAVE_SAW,    8'd128, 24'h123456, 24'h0ABCDE, 1'b0, 32'h0);
        step(1'b1, 1'b0, WAVE_SQUARE, 8'd100, 24'h800001, 24'h400000, 1'b0, 32'h0);
        step(1'b1, 1'b0, WAVE_TRI,    8'd77,  24'h3F0F0F, 24'h654321, 1'b0, 32'h0);
        step(1'b1, 1'b0, WAVE_SINE,   8'd255, 24'h111111, 24'h7FFFFF, 1'b0, 32'h0);
        idle();
        drain();
        checks++;
        if (strobes - snap != 4) begin
            errors++;
            $display("FAIL b2b_strobe_count: got %0d, required 4", strobes - snap);
        end

        // Reset lands while two samples are still in flight: they must vanish.
        step(1'b1, 1'b0, WAVE_SAW, 8'd128, 24'h010000, 24'h020000, 1'b0, 32'h0);
        step(1'b1, 1'b0, WAVE_SAW, 8'd128, 24'h010000, 24'h020000, 1'b0, 32'h0);
        snap = strobes;
        @(posedge clk);
        #1;
        rst_n = 1'b0; req = 1'b0;
        sb.delete();
        m_acc_l = '0; m_acc_r = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++;
        if (strobes != snap) begin
            errors++;
            $display("FAIL reset_flush_strobes: got %0d strobes, required 0", strobes - snap);
        end
        checks++;
        if (sample !== 32'h0) begin
            errors++;
            $display("FAIL reset_flush_sample: got %h, required 00000000", sample);
        end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_wrap();
        test_amplitude();
        test_sine();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tone_nco.md
Name: tone_nco

Overview:
- Parametrised stereo test-tone oscillator (NCO), successor of the single-sawtooth test tone.
- Two independent phase accumulators (left/right), each with its own frequency control word.
- Selectable waveform (saw, square, triangle, sine) with amplitude scaling.
- Feeds the audio output path: answers the codec's per-sample request with a packed stereo word and a valid strobe.

Parameters:
- ACC_W, 24: phase accumulator width; also the width of the FCW inputs.
- SAMPLE_W, 16: signed sample width per channel; phase word = acc[ACC_W-1 -: SAMPLE_W]; ACC_W >= SAMPLE_W.
- LUT_AW, 8: quarter-wave sine table address width (2^LUT_AW entries).

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- fcw_l_i  in  ACC_W  left frequency control word.
- fcw_r_i  in  ACC_W  right frequency control word.
- wave_i  in  2  waveform select: 0 SAW, 1 SQUARE, 2 TRIANGLE, 3 SINE.
- amp_i  in  8  amplitude; 128 = unity, values >128 saturate to 128.
- phase_rst_i  in  1  synchronous phase realign of both accumulators.
- sample_req_i  in  1  single-cycle request for the next sample.
- sample_o  out  2*SAMPLE_W  {left, right}; left in the upper half.
- sample_valid_o  out  1  one-cycle strobe when sample_o updates.

Behaviour:
- Reset (rst_ni low at clk edge): both accumulators = 0, all pipeline valids = 0, sample_o = 0, sample_valid_o = 0. Reset mid-pipeline discards in-flight samples; no strobe is emitted afterwards.
- Accept (S0), on sample_req_i:
  - acc_x <= acc_x + fcw_x, modulo 2^ACC_W; wrap is silent.
  - The emitted phase is the post-increment value.
  - wave_i and amp_i are captured into S1 on the same edge.
- Phase realign: phase_rst_i has priority over sample_req_i.
  - Both accumulators load 0.
  - If a request coincides, it is still accepted and emits phase 0 on both channels.
- Pipeline: S1 phase/mode, S2 waveform shaping (registered LUT read), S3 amplitude scale into the output register.
  - Latency: sample_valid_o is high exactly 3 cycles after the accepting edge.
  - Fully pipelined: requests on consecutive cycles produce consecutive strobes.
  - sample_o holds its value between strobes.
- Waveforms, with p = phase word and u = unsigned SAMPLE_W value:
  - SAW: out = p XOR MSB-mask (offset binary to two's complement).
  - SQUARE: p MSB 0 -> +(2^(SAMPLE_W-1)-1), else -(2^(SAMPLE_W-1)-1).
  - TRIANGLE: f = p MSB ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0]; u = {f, 0}; out = u XOR MSB-mask.
  - SINE: quadrant = p[top 2 bits]; idx = next LUT_AW bits.
    - Quadrants 1 and 3 use ~idx; quadrants 2 and 3 negate.
    - Table entry k = round((2^(SAMPLE_W-1)-1) * sin(pi/2 * (k+0.5) / 2^LUT_AW)).
- Scale: out = (wave * amp_sat) >>> 7, signed, arithmetic shift (floor). Intermediate width SAMPLE_W+9; the result always fits SAMPLE_W.
- fcw = 0 gives a constant (DC) output at the current phase. This is legal.

Optional Feature:
- Macro: TONE_NCO_SINE_EN.
- Defined: sine LUT sub-module instantiated; wave_i = 3 produces sine.
- Undefined: no LUT is built; wave_i = 3 produces TRIANGLE output with identical latency (S2 still registered).

Decomposition:
- Shared package tone_pkg:
  - enum wave_e {WAVE_SAW, WAVE_SQUARE, WAVE_TRI, WAVE_SINE} (2 bits).
  - AMP_UNITY = 128, AMP_SHIFT = 7.
- One sub-module, tone_sine_lut: registered quarter-wave ROM plus quadrant mirror/negate. Parameters SAMPLE_W and LUT_AW; one read per cycle.
- Two instances, one per channel. Instantiated only under TONE_NCO_SINE_EN.

Test Plan:
- Saw: ACC_W=24, fcw_l=fcw_r=0x010000, amp=128, one request -> strobe at +3 cycles, sample_o = 0x8100_8100; the next request gives 0x8200_8200.
- Wrap: square, fcw_l=0x800000, fcw_r=0, two requests -> left 0x8001 then 0x7FFF (acc wraps to 0); right 0x7FFF both times.
- Amplitude: square at phase 0, amp=64 -> 0x3FFF; at phase MSB=1 -> 0xC000 (floor). amp=200 gives the same output as amp=128.
- Sine (macro on): phase_rst_i with sample_req_i -> left = right = 101 (0x0065); with the macro off the same stimulus gives triangle 0x8000.
- Back-to-back: 4 requests on consecutive cycles -> 4 consecutive strobes, each matching the model; reset asserted after the 2nd request -> no further strobes, sample_o = 0.
